// File: rtl/serial_run_tx_if.sv
// Bundled start/data handshake and serial/status outputs of serial_run_tx.
// master = stimulus side, slave = transmitter.
interface serial_run_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             x_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;

  modport master (output start, data_in, input x_out, busy, done, hit_count);
  modport slave  (input start, data_in, output x_out, busy, done, hit_count);
endinterface

// File: rtl/serial_run_tx.sv
// Framed MSB-first serial transmitter that also predicts how many cycles a
// 3-or-more-consecutive-ones Mealy detector will flag for each frame.
module serial_run_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_run_tx_if.slave   bus,
  output logic [2:0]       state_dbg
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GUARD = 3'd1,
    S_SHIFT = 3'd2,
    S_TAIL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [1:0]       run, run_nx;
  logic [CNT_W-1:0] hit, hit_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             x_q, x_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;

  // Handshake: start is a level request honoured only on an edge seen in IDLE;
  // data_in is captured on that same edge. There is no back-pressure -- the
  // requester watches busy/done to know when another request will be taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      sh     <= '0;
      run    <= '0;
      hit    <= '0;
      idx    <= '0;
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sh     <= sh_nx;
      run    <= run_nx;
      hit    <= hit_nx;
      idx    <= idx_nx;
      x_q    <= x_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
    end
  end

  // x_q holds the payload bit currently on the line, so the run/hit update in
  // SHIFT looks at exactly the bit the detector is seeing this cycle.
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    run_nx   = run;
    hit_nx   = hit;
    idx_nx   = idx;
    x_nx     = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          sh_nx    = bus.data_in;
          hit_nx   = '0;
          run_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = S_GUARD;
        end
      end
      S_GUARD: begin
        busy_nx  = 1'b1;
        idx_nx   = IDX_W'(WIDTH - 1);
        x_nx     = sh[WIDTH-1];
        sh_nx    = {sh[WIDTH-2:0], 1'b0};
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy_nx = 1'b1;
        if (x_q) begin
          run_nx = (run == 2'd3) ? 2'd3 : run + 2'd1;
          if (run >= 2'd2) hit_nx = hit + CNT_W'(1);
        end else begin
          run_nx = 2'd0;
        end
        if (idx == '0) begin
          state_nx = S_TAIL;
        end else begin
          idx_nx = idx - IDX_W'(1);
          x_nx   = sh[WIDTH-1];
          sh_nx  = {sh[WIDTH-2:0], 1'b0};
        end
      end
      S_TAIL: begin
        done_nx  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.x_out     = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hit;
  assign state_dbg     = state;
endmodule

// File: tb/tb_serial_run_tx.sv
// Randomised and directed bench for serial_run_tx with an acceptance model,
// an expected-word queue and a monitor that checks every frame and idle cycle.
module tb_serial_run_tx;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  serial_run_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_run_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               model_cnt = 0;
  int               accepts = 0;
  int               last_hit = 0;
  bit               collecting = 0;
  int               blen = 0;
  logic [WIDTH+1:0] got_stream;
  logic [WIDTH-1:0] cur_word;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Detector hits: every payload position whose bit and the two bits sent just
  // before it are all ones (the guard 0 means no run enters from outside).
  function automatic int ref_hits(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int j = 0; j <= WIDTH - 3; j++)
      if (w[j] && w[j+1] && w[j+2]) n++;
    return n;
  endfunction

  // Acceptance model: a request is taken only when the previous frame has
  // fully retired; a frame occupies WIDTH+3 edges after its accepting edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_cnt = 0;
      exp_q.delete();
    end else if (model_cnt == 0) begin
      if (bus.start) begin
        exp_q.push_back(bus.data_in);
        model_cnt = WIDTH + 3;
        accepts++;
      end
    end else begin
      model_cnt--;
    end
  end

  always @(negedge rst) begin
    #1;
    last_hit = 0;
    check("reset_x_out", int'(bus.x_out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_hit_count", int'(bus.hit_count), 0);
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      collecting = 0;
    end else if (bus.busy) begin
      if (!collecting) begin
        collecting = 1;
        blen = 0;
        got_stream = '0;
        check("frame_start_timing", model_cnt, WIDTH + 3);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          cur_word = '0;
        end else begin
          cur_word = exp_q.pop_front();
        end
      end
      got_stream = {got_stream[WIDTH:0], bus.x_out};
      blen++;
    end else if (bus.done) begin
      if (!collecting) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("busy_length", blen, WIDTH + 2);
        check("serial_stream", int'(got_stream), int'({1'b0, cur_word, 1'b0}));
        check("hit_count", int'(bus.hit_count), ref_hits(cur_word));
        check("done_timing", model_cnt, 1);
        last_hit = ref_hits(cur_word);
      end
      collecting = 0;
    end else begin
      if (collecting) begin
        check("frame_ended_without_done", 1, 0);
        collecting = 0;
      end
      check("idle_x_out", int'(bus.x_out), 0);
      check("idle_hit_hold", int'(bus.hit_count), last_hit);
    end
  end

  // driver tasks
  task automatic wait_idle();
    int i;
    for (i = 0; i < 60 && model_cnt != 0; i++) @(negedge clk);
    if (model_cnt != 0) check("wait_idle_timeout", model_cnt, 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    wait_idle();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = w;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_idle();
  endtask

  task automatic wait_accepts(input int target);
    int i;
    for (i = 0; i < 100 && accepts < target; i++) @(negedge clk);
    if (accepts < target) check("accept_timeout", accepts, target);
  endtask

  initial begin
    int a0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);

    send(8'b1111_0000);
    send(8'hFF);
    send(8'b1011_0111);
    send(8'h00);

    // Requests during busy and during DONE with data_in churning must not disturb the frame.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'b1110_1110;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < WIDTH + 2; c++) begin
      bus.data_in = WIDTH'($urandom);
      bus.start   = (model_cnt == 1) || (c % 3 == 1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();

    // start held high: back-to-back frames with exactly one idle cycle between.
    a0 = accepts;
    bus.data_in = 8'hE0;
    bus.start   = 1'b1;
    wait_accepts(a0 + 1);
    bus.data_in = 8'h07;
    wait_accepts(a0 + 2);
    bus.data_in = 8'hFF;
    wait_accepts(a0 + 3);
    bus.start = 1'b0;
    wait_idle();

    // Reset while payload bit 4 is on the line.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'b1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && model_cnt != 7; i++) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(8'b0111_0110);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.data_in = WIDTH'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();

    for (int i = 0; i < 20 && (exp_q.size() != 0 || collecting); i++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_no_open_frame", int'(collecting), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_run_tx.md
Name: serial_run_tx

Overview:
- Serial stimulus transmitter for the consecutive-ones detector. It drives that detector's serial input x_in.
- Accepts a parallel word on a start strobe and shifts it out MSB first, one bit per clk.
- Each frame is bracketed by a leading guard 0 and a trailing 0, so the downstream detector returns to its idle state between frames.
- Computes in-line the number of cycles on which a 3-or-more-consecutive-ones Mealy detector would assert its output. The bench compares this against the detector's output.

Parameters:
- WIDTH, 8, payload bits per frame (minimum 3).
- CNT_W, 4, width of hit_count; must hold WIDTH-2.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  WIDTH  payload; captured on the accepted start edge.
- x_out  output  1  registered serial bit stream.
- busy  output  1  high from the cycle after start is accepted through the TAIL bit.
- done  output  1  one-cycle pulse after the frame completes.
- hit_count  output  CNT_W  predicted detector hits for the last frame.

Behaviour:
- Reset (async, rst=0): state=IDLE, x_out=0, busy=0, done=0, hit_count=0, shift register=0, run counter=0.
  - Asserting reset mid-frame aborts the frame immediately; no done pulse follows.
- IDLE:
  - x_out=0, busy=0, done=0.
  - On the rising edge with start=1: latch data_in into the shift register, clear hit_count and the run counter, go to GUARD.
- GUARD (1 cycle): x_out=0, busy=1. On the next edge go to SHIFT with bit index WIDTH-1.
- SHIFT (WIDTH cycles):
  - x_out = current payload bit, MSB first; busy=1.
  - On each edge, update the 2-bit run counter, saturating at 3.
    - If the bit is 1: run <= min(run+1, 3).
    - If the bit is 0: run <= 0.
  - hit_count increments on a bit where bit=1 and run>=2, i.e. the 3rd or later consecutive 1. This matches the detector's Mealy y_out=1 cycles exactly.
  - After bit 0 go to TAIL.
- TAIL (1 cycle): x_out=0, busy=1. Next go to DONE.
- DONE (1 cycle): x_out=0, busy=0, done=1, hit_count final. Next go to IDLE.
- Frame timing:
  - start accepted at edge k.
  - GUARD occupies k..k+1; payload bit i (MSB = index WIDTH-1) appears after edge k+WIDTH-i.
  - TAIL follows edge k+WIDTH+1; done=1 follows edge k+WIDTH+2.
  - busy is high for WIDTH+2 cycles.
- start is ignored in GUARD, SHIFT, TAIL and DONE. With start held high continuously, the next frame is accepted on the first IDLE edge, giving one idle cycle between frames.
- data_in changes after acceptance do not affect the frame in flight.
- hit_count holds its value after DONE until the next accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Zero-gap rule: a run of ones never spans two frames, because GUARD and TAIL both force 0.

Test Plan:
- Reset sequence: rst=0 at t=2, released at t=4 -> x_out=0, busy=0, done=0, hit_count=0 throughout; no activity without start.
- data_in=8'b11110000, single start pulse -> x_out = 0,1,1,1,1,0,0,0,0,0 (guard, payload, tail); busy high 10 cycles; done pulse; hit_count=2. A connected detector shows 2 y_out cycles.
- data_in=8'hFF -> hit_count=6.
- data_in=8'b10110111 -> hit_count=1.
- data_in=8'h00 -> hit_count=0 and x_out stays 0.
- Start pulses during busy and during DONE, with data_in changed mid-frame -> both ignored; frame matches the originally latched word; exactly one done.
- start held high for 3 frames with data 8'hE0, 8'h07, 8'hFF -> one idle cycle between frames; hit_count 1, 1, 6. The detector never counts across frames.
- rst=0 asserted during SHIFT bit 4 -> all outputs 0 immediately; no done. After release, a fresh start frame is correct.
